// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller.
//   pipe_state_e : controller FSM state (RUN / MWAIT / ERR)
//   FWD_*        : EX operand mux select encodings
//   fwd_sel()    : forwarding select for one EX source register
package pipe_ctrl_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    ERR   = 2'd2
  } pipe_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // MEM result is younger than WB, so it takes precedence when both match.
  function automatic logic [1:0] fwd_sel(input logic             mem_regwr,
                                         input logic [REG_W-1:0] mem_rw,
                                         input logic             wb_regwr,
                                         input logic [REG_W-1:0] wb_rw,
                                         input logic [REG_W-1:0] src);
    if (mem_regwr && (mem_rw != '0) && (mem_rw == src)) return FWD_MEM;
    if (wb_regwr && (wb_rw != '0) && (wb_rw == src))    return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bus between the pipeline datapath (master) and pipe_ctrl (slave).
//   ID/EX/MEM/WB register ids and control bits, DMem_Ready   : master -> slave
//   write enables, flushes, forward selects, DMem_Req, MemErr : slave -> master
//   Stall_Cnt / Flush_Cnt : statistics, only with PIPE_CTRL_STATS_EN defined
interface pipe_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  import pipe_ctrl_pkg::*;

  typedef logic [CNT_W-1:0] cnt_t;

  logic [REG_W-1:0] ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_Rw, MEM_Rw, WB_Rw;
  logic             ID_UsesRt, EX_MemtoReg;
  logic             MEM_RegWr, MEM_MemtoReg, MEM_MemWr, MEM_PCSrc;
  logic             WB_RegWr, DMem_Ready;
  logic             PC_Wr, IFID_Wr, EXMEM_Wr, MEMWB_Wr;
  logic             IFID_Flush, IDEX_Flush;
  logic [1:0]       ForwardA, ForwardB;
  logic             DMem_Req, MemErr;
`ifdef PIPE_CTRL_STATS_EN
  cnt_t             Stall_Cnt, Flush_Cnt;
`endif

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt, EX_Rs, EX_Rt, EX_Rw, EX_MemtoReg,
           MEM_Rw, MEM_RegWr, MEM_MemtoReg, MEM_MemWr, MEM_PCSrc,
           WB_Rw, WB_RegWr, DMem_Ready,
    input  PC_Wr, IFID_Wr, EXMEM_Wr, MEMWB_Wr, IFID_Flush, IDEX_Flush,
           ForwardA, ForwardB, DMem_Req, MemErr
`ifdef PIPE_CTRL_STATS_EN
           , Stall_Cnt, Flush_Cnt
`endif
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt, EX_Rs, EX_Rt, EX_Rw, EX_MemtoReg,
           MEM_Rw, MEM_RegWr, MEM_MemtoReg, MEM_MemWr, MEM_PCSrc,
           WB_Rw, WB_RegWr, DMem_Ready,
    output PC_Wr, IFID_Wr, EXMEM_Wr, MEMWB_Wr, IFID_Flush, IDEX_Flush,
           ForwardA, ForwardB, DMem_Req, MemErr
`ifdef PIPE_CTRL_STATS_EN
           , Stall_Cnt, Flush_Cnt
`endif
  );

endinterface

// File: rtl/pipe_ctrl_fwd_unit.sv
// Combinational EX operand forwarding unit.
//   Inputs : MEM/WB writeback ids and enables, EX source ids
//   Outputs: ForwardA (for EX_Rs), ForwardB (for EX_Rt)
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic             MEM_RegWr,
  input  logic [REG_W-1:0] MEM_Rw,
  input  logic             WB_RegWr,
  input  logic [REG_W-1:0] WB_Rw,
  input  logic [REG_W-1:0] EX_Rs,
  input  logic [REG_W-1:0] EX_Rt,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB
);

  assign ForwardA = fwd_sel(MEM_RegWr, MEM_Rw, WB_RegWr, WB_Rw, EX_Rs);
  assign ForwardB = fwd_sel(MEM_RegWr, MEM_Rw, WB_RegWr, WB_Rw, EX_Rt);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory-wait
// freeze with timeout, and operand forwarding. State changes on the falling
// clock edge, in step with the pipeline registers.
//   Clk, Rst : clock, synchronous active-high reset
//   bus      : pipe_ctrl_if.slave (see interface header)
// Optional: PIPE_CTRL_STATS_EN adds saturating Stall_Cnt / Flush_Cnt.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned WAIT_MAX = 8
) (
  input  logic      Clk,
  input  logic      Rst,
  pipe_ctrl_if.slave bus
);

  pipe_state_e      state_q, state_d, cur_state;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             dmem_req, freeze, load_use;
  logic             pc_wr, ifid_wr, exmem_wr, memwb_wr, ifid_fl, idex_fl, mem_err;

  // While reset is held the outputs behave as in RUN.
  assign cur_state = Rst ? RUN : state_q;

  assign dmem_req = bus.MEM_MemtoReg | bus.MEM_MemWr;
  assign freeze   = dmem_req & ~bus.DMem_Ready;
  assign load_use = bus.EX_MemtoReg && (bus.EX_Rw != '0) &&
                    ((bus.EX_Rw == bus.ID_Rs) || (bus.ID_UsesRt && (bus.EX_Rw == bus.ID_Rt)));

  // State register.
  always_ff @(negedge Clk) begin
    if (Rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next state and hazard outputs; priority freeze > branch flush > load-use.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pc_wr      = 1'b1;
    ifid_wr    = 1'b1;
    exmem_wr   = 1'b1;
    memwb_wr   = 1'b1;
    ifid_fl    = 1'b0;
    idex_fl    = 1'b0;
    mem_err    = 1'b0;

    unique case (state_q)
      RUN: begin
        if (freeze) begin
          state_d    = MWAIT;
          wait_cnt_d = '0;
        end
      end
      MWAIT: begin
        if (bus.DMem_Ready)                            state_d = RUN;
        else if (wait_cnt_q == CNT_W'(WAIT_MAX - 1))   state_d = ERR;
        else                                           wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase

    if (cur_state == ERR) begin
      {pc_wr, ifid_wr, exmem_wr, memwb_wr} = 4'b0000;
      mem_err = 1'b1;
    end else if (freeze) begin
      {pc_wr, ifid_wr, exmem_wr, memwb_wr} = 4'b0000;
    end else if (bus.MEM_PCSrc) begin
      ifid_fl = 1'b1;
      idex_fl = 1'b1;
    end else if (load_use) begin
      pc_wr   = 1'b0;
      ifid_wr = 1'b0;
      idex_fl = 1'b1;
    end
  end

  assign bus.DMem_Req   = dmem_req;
  assign bus.PC_Wr      = pc_wr;
  assign bus.IFID_Wr    = ifid_wr;
  assign bus.EXMEM_Wr   = exmem_wr;
  assign bus.MEMWB_Wr   = memwb_wr;
  assign bus.IFID_Flush = ifid_fl;
  assign bus.IDEX_Flush = idex_fl;
  assign bus.MemErr     = mem_err;

  fwd_unit u_fwd (
    .MEM_RegWr (bus.MEM_RegWr),
    .MEM_Rw    (bus.MEM_Rw),
    .WB_RegWr  (bus.WB_RegWr),
    .WB_Rw     (bus.WB_Rw),
    .EX_Rs     (bus.EX_Rs),
    .EX_Rt     (bus.EX_Rt),
    .ForwardA  (bus.ForwardA),
    .ForwardB  (bus.ForwardB)
  );

`ifdef PIPE_CTRL_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_act;

  // IDEX flush without IFID flush only happens for a load-use stall.
  assign stall_act = freeze | (idex_fl & ~ifid_fl);

  // Saturating statistics counters.
  always_ff @(negedge Clk) begin
    if (Rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_act && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (ifid_fl && (flush_cnt_q != '1))   flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.Stall_Cnt = stall_cnt_q;
  assign bus.Flush_Cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table vectors, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int unsigned TB_CNT_W    = 6;
  localparam int unsigned TB_WAIT_MAX = 8;
  localparam int          CNT_MAX     = (1 << TB_CNT_W) - 1;

  typedef struct packed {
    logic [4:0] id_rs, id_rt; logic id_usesrt;
    logic [4:0] ex_rs, ex_rt, ex_rw; logic ex_m2r;
    logic [4:0] mem_rw; logic mem_regwr, mem_m2r, mem_memwr, pcsrc;
    logic [4:0] wb_rw; logic wb_regwr, ready;
  } in_t;

  typedef struct packed {
    logic pc, ifid, exmem, memwb, ifl, idl;
    logic [1:0] fa, fb;
    logic req, err;
  } exp_t;

  typedef struct packed { in_t in; exp_t exp; } vec_t;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  pipe_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();
  pipe_ctrl #(.CNT_W(TB_CNT_W), .WAIT_MAX(TB_WAIT_MAX)) dut (.Clk(Clk), .Rst(Rst), .bus(bus.slave));

  int n_cmp = 0, n_fail = 0;
  in_t cur;
  bit  m_err = 0;
  int  m_wait = -1;   // cycles spent waiting for memory; -1 when not waiting
  int  m_stall = 0, m_flush = 0;

  function automatic in_t mk_in(int rs, int rt, int ut, int exs, int ext, int exw, int exm,
                                int mw, int mrw, int mm2r, int mmw, int pcs, int ww, int wrw, int rdy);
    in_t v;
    v.id_rs = 5'(rs); v.id_rt = 5'(rt); v.id_usesrt = 1'(ut);
    v.ex_rs = 5'(exs); v.ex_rt = 5'(ext); v.ex_rw = 5'(exw); v.ex_m2r = 1'(exm);
    v.mem_rw = 5'(mw); v.mem_regwr = 1'(mrw); v.mem_m2r = 1'(mm2r); v.mem_memwr = 1'(mmw);
    v.pcsrc = 1'(pcs); v.wb_rw = 5'(ww); v.wb_regwr = 1'(wrw); v.ready = 1'(rdy);
    return v;
  endfunction

  function automatic exp_t mk_exp(logic [3:0] wr, logic [1:0] fl, logic [1:0] fa, logic [1:0] fb, logic req);
    return {wr, fl, fa, fb, req, 1'b0};
  endfunction

  function automatic bit is_lu(in_t i);
    return i.ex_m2r && i.ex_rw != 0 && (i.ex_rw == i.id_rs || (i.id_usesrt && i.ex_rw == i.id_rt));
  endfunction

  function automatic logic [1:0] m_fwd(in_t i, logic [4:0] src);
    if (i.mem_regwr && i.mem_rw != 0 && i.mem_rw == src) return 2'b10;
    if (i.wb_regwr && i.wb_rw != 0 && i.wb_rw == src)    return 2'b01;
    return 2'b00;
  endfunction

  // Expected outputs for input set i, reset level r, model error flag e.
  function automatic exp_t model_out(in_t i, logic r, bit e);
    exp_t o;
    bit req = i.mem_m2r | i.mem_memwr;
    bit in_err = e && !r;
    o = '0;
    o.req = req; o.err = in_err;
    o.fa = m_fwd(i, i.ex_rs); o.fb = m_fwd(i, i.ex_rt);
    if (in_err || (req && !i.ready)) begin
      {o.pc, o.ifid, o.exmem, o.memwb} = 4'b0000;
    end else if (i.pcsrc) begin
      {o.pc, o.ifid, o.exmem, o.memwb, o.ifl, o.idl} = 6'b111111;
    end else if (is_lu(i)) begin
      {o.pc, o.ifid, o.exmem, o.memwb, o.ifl, o.idl} = 6'b001101;
    end else begin
      {o.pc, o.ifid, o.exmem, o.memwb} = 4'b1111;
    end
    return o;
  endfunction

  function automatic exp_t get_dut();
    return {bus.PC_Wr, bus.IFID_Wr, bus.EXMEM_Wr, bus.MEMWB_Wr, bus.IFID_Flush, bus.IDEX_Flush,
            bus.ForwardA, bus.ForwardB, bus.DMem_Req, bus.MemErr};
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(in_t v);
    cur = v;
    bus.ID_Rs = v.id_rs; bus.ID_Rt = v.id_rt; bus.ID_UsesRt = v.id_usesrt;
    bus.EX_Rs = v.ex_rs; bus.EX_Rt = v.ex_rt; bus.EX_Rw = v.ex_rw; bus.EX_MemtoReg = v.ex_m2r;
    bus.MEM_Rw = v.mem_rw; bus.MEM_RegWr = v.mem_regwr; bus.MEM_MemtoReg = v.mem_m2r;
    bus.MEM_MemWr = v.mem_memwr; bus.MEM_PCSrc = v.pcsrc;
    bus.WB_Rw = v.wb_rw; bus.WB_RegWr = v.wb_regwr; bus.DMem_Ready = v.ready;
  endtask

  // Sample mid-cycle (rising edge; state moves on the falling edge).
  task automatic sample(string name);
    @(posedge Clk);
    chk({name, "/outs"}, 16'(get_dut()), 16'(model_out(cur, Rst, m_err)));
`ifdef PIPE_CTRL_STATS_EN
    chk({name, "/stall_cnt"}, 16'(bus.Stall_Cnt), 16'(m_stall));
    chk({name, "/flush_cnt"}, 16'(bus.Flush_Cnt), 16'(m_flush));
`endif
  endtask

  // Apply the falling edge to the model and the DUT.
  task automatic advance();
    exp_t e = model_out(cur, Rst, m_err);
    bit frz = (cur.mem_m2r | cur.mem_memwr) && !cur.ready;
    if (Rst) begin
      m_err = 0; m_wait = -1; m_stall = 0; m_flush = 0;
    end else begin
      if ((frz || (e.idl && !e.ifl)) && m_stall < CNT_MAX) m_stall++;
      if (e.ifl && m_flush < CNT_MAX) m_flush++;
      if (!m_err) begin
        if (m_wait < 0)                     begin if (frz) m_wait = 0; end
        else if (cur.ready)                 m_wait = -1;
        else if (m_wait >= TB_WAIT_MAX - 1) m_err = 1;
        else                                m_wait++;
      end
    end
    @(negedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    drive(mk_in(0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,1));
    sample("reset");
    chk("reset/memerr", 16'(bus.MemErr), 16'h0);
    advance();
    Rst = 1'b0;
  endtask

  vec_t tbl [11];

  initial begin
    // Table vectors are applied with Rst held so the controller stays in RUN.
    tbl[0]  = '{mk_in(0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,1), mk_exp(4'b1111, 2'b00, 2'b00, 2'b00, 0)};
    tbl[1]  = '{mk_in(5,0,0, 0,0,5,1, 0,0,0,0,0, 0,0,1), mk_exp(4'b0011, 2'b01, 2'b00, 2'b00, 0)};
    tbl[2]  = '{mk_in(1,6,0, 0,0,6,1, 0,0,0,0,0, 0,0,1), mk_exp(4'b1111, 2'b00, 2'b00, 2'b00, 0)};
    tbl[3]  = '{mk_in(1,6,1, 0,0,6,1, 0,0,0,0,0, 0,0,1), mk_exp(4'b0011, 2'b01, 2'b00, 2'b00, 0)};
    tbl[4]  = '{mk_in(0,0,1, 0,0,0,1, 0,0,0,0,0, 0,0,1), mk_exp(4'b1111, 2'b00, 2'b00, 2'b00, 0)};
    tbl[5]  = '{mk_in(5,0,0, 0,0,5,1, 0,0,0,0,1, 0,0,1), mk_exp(4'b1111, 2'b11, 2'b00, 2'b00, 0)};
    tbl[6]  = '{mk_in(5,0,0, 0,0,5,1, 0,0,0,1,1, 0,0,0), mk_exp(4'b0000, 2'b00, 2'b00, 2'b00, 1)};
    tbl[7]  = '{mk_in(0,0,0, 0,0,0,0, 0,0,1,0,0, 0,0,1), mk_exp(4'b1111, 2'b00, 2'b00, 2'b00, 1)};
    tbl[8]  = '{mk_in(0,0,0, 7,3,0,0, 7,1,0,0,0, 7,1,1), mk_exp(4'b1111, 2'b00, 2'b10, 2'b00, 0)};
    tbl[9]  = '{mk_in(0,0,0, 7,3,0,0, 7,0,0,0,0, 3,1,1), mk_exp(4'b1111, 2'b00, 2'b00, 2'b01, 0)};
    tbl[10] = '{mk_in(0,0,0, 0,0,0,0, 0,1,0,0,0, 0,1,1), mk_exp(4'b1111, 2'b00, 2'b00, 2'b00, 0)};

    do_reset();

    Rst = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].in);
      sample($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d/exp", i), 16'(get_dut()), 16'(tbl[i].exp));
      advance();
    end
    Rst = 1'b0;
    do_reset();

    // Load-use stall for one cycle, then the bubble reaches EX.
    drive(mk_in(5,0,0, 0,0,5,1, 0,0,0,0,0, 0,0,1));
    sample("lu");
    chk("lu/pc_wr", 16'(bus.PC_Wr), 16'h0);
    chk("lu/ifid_wr", 16'(bus.IFID_Wr), 16'h0);
    chk("lu/idex_flush", 16'(bus.IDEX_Flush), 16'h1);
    advance();
    drive(mk_in(5,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,1));
    sample("lu_bubble");
    chk("lu_bubble/wr", 16'({bus.PC_Wr, bus.IFID_Wr, bus.EXMEM_Wr, bus.MEMWB_Wr}), 16'hF);
    advance();

    // Branch flush wins over load-use.
    do_reset();
    drive(mk_in(5,0,0, 0,0,5,1, 0,0,0,0,1, 0,0,1));
    sample("br_lu");
    chk("br_lu/flush", 16'({bus.IFID_Flush, bus.IDEX_Flush, bus.PC_Wr}), 16'h7);
    advance();
    drive(mk_in(0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,1));
    sample("br_after");
`ifdef PIPE_CTRL_STATS_EN
    chk("br_after/flush_cnt", 16'(bus.Flush_Cnt), 16'h1);
`endif
    advance();

    // Three-cycle memory wait, then Ready; no error.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(mk_in(0,0,0, 0,0,0,0, 0,0,1,0,0, 0,0,(k == 3) ? 1 : 0));
      sample($sformatf("mwait%0d", k));
      chk($sformatf("mwait%0d/wr", k), 16'({bus.PC_Wr, bus.IFID_Wr, bus.EXMEM_Wr, bus.MEMWB_Wr}),
          (k == 3) ? 16'hF : 16'h0);
      chk($sformatf("mwait%0d/memerr", k), 16'(bus.MemErr), 16'h0);
      advance();
    end

    // Timeout: one RUN freeze cycle plus WAIT_MAX cycles in MWAIT, then ERR.
    for (int k = 0; k < 12; k++) begin
      drive(mk_in(0,0,0, 0,0,0,0, 0,0,1,0,0, 0,0,0));
      sample($sformatf("tmo%0d", k));
      chk($sformatf("tmo%0d/memerr", k), 16'(bus.MemErr), (k >= 9) ? 16'h1 : 16'h0);
      advance();
    end
    drive(mk_in(0,0,0, 0,0,0,0, 0,0,1,0,0, 0,0,1));
    sample("err_ready");
    chk("err_ready/pc_req_err", 16'({bus.PC_Wr, bus.DMem_Req, bus.MemErr}), 16'h3);
    advance();
    Rst = 1'b1;
    sample("err_rst");
    chk("err_rst/memerr_pc", 16'({bus.MemErr, bus.PC_Wr}), 16'h1);
    advance();
    Rst = 1'b0;
    sample("err_clear");
    chk("err_clear/memerr_pc", 16'({bus.MemErr, bus.PC_Wr}), 16'h1);
    advance();

    // Forwarding: MEM wins over WB; register 0 never forwards.
    drive(mk_in(0,0,0, 7,0,0,0, 7,1,0,0,0, 7,1,1));
    sample("fwd_both");
    chk("fwd_both/fa", 16'(bus.ForwardA), 16'h2);
    advance();
    drive(mk_in(0,0,0, 0,0,0,0, 0,1,0,0,0, 0,1,1));
    sample("fwd_r0");
    chk("fwd_r0/fa", 16'(bus.ForwardA), 16'h0);
    advance();

`ifdef PIPE_CTRL_STATS_EN
    // Stall counter saturation.
    do_reset();
    drive(mk_in(5,0,0, 0,0,5,1, 0,0,0,0,0, 0,0,1));
    for (int k = 0; k < CNT_MAX + 7; k++) begin
      sample("sat");
      advance();
    end
    drive(mk_in(0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,1));
    sample("sat_end");
    chk("sat_end/stall_cnt", 16'(bus.Stall_Cnt), 16'(CNT_MAX));
    chk("sat_end/flush_cnt", 16'(bus.Flush_Cnt), 16'h0);
    advance();
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      Rst = ($urandom_range(0, 99) < 3);
      drive(mk_in($urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,1),
                  $urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,1),
                  $urandom_range(0,3), $urandom_range(0,1), $urandom_range(0,1),
                  ($urandom_range(0,3) == 0), ($urandom_range(0,7) == 0),
                  $urandom_range(0,3), $urandom_range(0,1), ($urandom_range(0,99) < 70)));
      sample("rand");
      advance();
    end
    Rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
